// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one BCD digit (0-9) with enable, parallel load, carry pulse; down-count when BCD_DOWN_COUNT_EN.
// Latency: en/ld sampled at an edge, digit/chg/co/err registered on that edge; only ld_rdy is combinational.
// Backpressure: ld_rdy low when ld_vld is low, the value is > 9, or rst is high; rejected values set sticky err.
module bcd_digit_counter #(
  parameter logic [3:0] START = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dn,
  input  logic       ld_vld,
  input  logic [3:0] ld_val,
  output logic       ld_rdy,
  output logic       b3,
  output logic       b2,
  output logic       b1,
  output logic       b0,
  output logic       chg,
  output logic       co,
  output logic       err
);

  localparam logic [3:0] START_Q = (START > 4'd9) ? 4'd0 : START;

  logic [3:0] q;
  logic [3:0] q_nxt;
  logic       co_nxt;
  logic       ld_ok;
  logic       ld_bad;
  logic [3:0] up_q;
  logic       up_co;
  logic [3:0] step_q;
  logic       step_co;

  assign ld_ok  = ld_vld && (ld_val <= 4'd9);
  assign ld_bad = ld_vld && (ld_val > 4'd9);
  assign ld_rdy = ld_ok && !rst;

  assign up_co = (q == 4'd9);
  assign up_q  = up_co ? 4'd0 : q + 4'd1;

`ifdef BCD_DOWN_COUNT_EN
  logic [3:0] down_q;
  logic       down_co;

  assign down_co = (q == 4'd0);
  assign down_q  = down_co ? 4'd9 : q - 4'd1;
  assign step_q  = dn ? down_q : up_q;
  assign step_co = dn ? down_co : up_co;
`else
  logic unused_dn;

  assign unused_dn = dn;
  assign step_q    = up_q;
  assign step_co   = up_co;
`endif

  // Any load request, legal or not, consumes the cycle: the count step is dropped.
  always_comb begin
    q_nxt  = q;
    co_nxt = 1'b0;
    if (ld_ok) begin
      q_nxt = ld_val;
    end else if (en && !ld_vld) begin
      q_nxt  = step_q;
      co_nxt = step_co;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= START_Q;
      chg <= 1'b0;
      co  <= 1'b0;
      err <= 1'b0;
    end else begin
      q   <= q_nxt;
      chg <= (q_nxt != q);
      co  <= co_nxt;
      if (ld_bad) begin
        err <= 1'b1;
      end
    end
  end

  assign {b3, b2, b1, b0} = q;

endmodule
